// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl: front-of-pipeline sequencing for the LC-3b.
// Generates PC / DE / AGEX load enables, the DE valid bit and the PC mux
// select; suppresses fetch while a control-flow instruction is in flight,
// counts fetch stalls and resolved branches, and flags a sticky error if a
// pending branch never resolves.
module pipeline_fetch_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MAX_BR_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             icache_r,
    input  logic             dep_stall,
    input  logic             v_de_br_stall,
    input  logic             v_agex_br_stall,
    input  logic             v_mem_br_stall,
    input  logic             mem_stall,
    input  logic [1:0]       mem_pcmux,
    output logic             ld_pc,
    output logic [1:0]       pcmux_sel,
    output logic             ld_de,
    output logic             de_v_in,
    output logic             ld_agex,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic             br_timeout_err
);

    localparam int BW = (MAX_BR_WAIT > 2) ? $clog2(MAX_BR_WAIT) : 1;
    localparam logic [BW-1:0] WAIT_LAST = BW'(MAX_BR_WAIT - 1);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        BR_PEND = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [BW-1:0] br_wait;

    logic stall_inc;
    logic br_inc;
    logic wait_clr;
    logic wait_inc;
    logic err_set;
    logic resolve;

    assign ctrl_state = state;
    assign resolve    = v_mem_br_stall & ~mem_stall;

    // State register and counters; reset drops any pending branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= BOOT;
            stall_cnt      <= '0;
            br_cnt         <= '0;
            br_wait        <= '0;
            br_timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (br_inc && (br_cnt != '1))
                br_cnt <= br_cnt + 1'b1;
            if (wait_clr)
                br_wait <= '0;
            else if (wait_inc)
                br_wait <= br_wait + 1'b1;
            if (err_set)
                br_timeout_err <= 1'b1;
        end
    end

    // Next-state and load-enable decode from registered state plus inputs.
    always_comb begin
        state_nx  = state;
        ld_pc     = 1'b0;
        pcmux_sel = 2'd0;
        ld_de     = ~mem_stall;
        de_v_in   = 1'b0;
        ld_agex   = ~mem_stall;
        stall_inc = 1'b0;
        br_inc    = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        err_set   = 1'b0;

        case (state)
            BOOT: begin
                ld_de    = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                ld_de   = ~mem_stall & ~dep_stall;
                de_v_in = icache_r & ~v_de_br_stall;
                ld_pc   = icache_r & ~mem_stall & ~dep_stall & ~v_de_br_stall
                        & ~v_agex_br_stall & ~v_mem_br_stall;
                if (v_de_br_stall && !dep_stall && !mem_stall) begin
                    ld_de    = 1'b1;
                    de_v_in  = 1'b0;
                    state_nx = BR_PEND;
                    wait_clr = 1'b1;
                end
                stall_inc = ~ld_pc;
            end
            BR_PEND: begin
                ld_de = ~mem_stall;
                if (resolve) begin
                    ld_pc     = 1'b1;
                    pcmux_sel = (mem_pcmux == 2'd3) ? 2'd0 : mem_pcmux;
                    br_inc    = 1'b1;
                    state_nx  = RUN;
                end else if (!mem_stall) begin
                    if (br_wait == WAIT_LAST) begin
                        err_set  = 1'b1;
                        wait_clr = 1'b1;
                        state_nx = RUN;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end
            default: state_nx = BOOT;
        endcase

        if (!reset_n) begin
            ld_pc     = 1'b0;
            pcmux_sel = 2'd0;
            ld_de     = 1'b1;
            de_v_in   = 1'b0;
            ld_agex   = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// tb_pipeline_fetch_ctrl: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the fetch sequencing rules.
module tb_pipeline_fetch_ctrl;

    localparam int CNT_W   = 4;
    localparam int MAXW    = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             icache_r, dep_stall, v_de_br_stall, v_agex_br_stall;
    logic             v_mem_br_stall, mem_stall;
    logic [1:0]       mem_pcmux;
    logic             ld_pc, ld_de, de_v_in, ld_agex, br_timeout_err;
    logic [1:0]       pcmux_sel, ctrl_state;
    logic [CNT_W-1:0] stall_cnt, br_cnt;

    pipeline_fetch_ctrl #(.CNT_W(CNT_W), .MAX_BR_WAIT(MAXW)) dut (
        .clk(clk), .reset_n(reset_n), .icache_r(icache_r), .dep_stall(dep_stall),
        .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
        .v_mem_br_stall(v_mem_br_stall), .mem_stall(mem_stall), .mem_pcmux(mem_pcmux),
        .ld_pc(ld_pc), .pcmux_sel(pcmux_sel), .ld_de(ld_de), .de_v_in(de_v_in),
        .ld_agex(ld_agex), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt),
        .br_cnt(br_cnt), .br_timeout_err(br_timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model state: mode 0 boot, 1 running, 2 waiting on branch.
    int m_mode, m_stall, m_br, m_wait, m_err;
    int e_ld_pc, e_sel, e_ld_de, e_dev, e_ld_agex;
    logic [16:0] exp_vec;
    logic [16:0] obs_vec;

    assign obs_vec = {ld_pc, pcmux_sel, ld_de, de_v_in, ld_agex, ctrl_state,
                      br_timeout_err, stall_cnt, br_cnt};

    task automatic model_reset();
        m_mode = 0; m_stall = 0; m_br = 0; m_wait = 0; m_err = 0;
    endtask

    // Expected combinational outputs for the current inputs.
    task automatic model_comb();
        e_ld_pc = 0; e_sel = 0; e_dev = 0;
        e_ld_agex = mem_stall ? 0 : 1;
        e_ld_de = e_ld_agex;
        if (!reset_n) begin
            e_ld_de = 1; e_ld_agex = 1;
        end else if (m_mode == 0) begin
            e_ld_de = 1;
        end else if (m_mode == 1) begin
            e_ld_de = (!mem_stall && !dep_stall) ? 1 : 0;
            e_dev   = (icache_r && !v_de_br_stall) ? 1 : 0;
            e_ld_pc = (icache_r && !mem_stall && !dep_stall && !v_de_br_stall &&
                       !v_agex_br_stall && !v_mem_br_stall) ? 1 : 0;
            if (v_de_br_stall && !dep_stall && !mem_stall) begin
                e_ld_de = 1; e_dev = 0; e_ld_pc = 0;
            end
        end else if (v_mem_br_stall && !mem_stall) begin
            e_ld_pc = 1;
            e_sel   = (mem_pcmux == 2'd3) ? 0 : int'(mem_pcmux);
        end
        exp_vec = {e_ld_pc[0], e_sel[1:0], e_ld_de[0], e_dev[0], e_ld_agex[0],
                   m_mode[1:0], m_err[0], m_stall[CNT_W-1:0], m_br[CNT_W-1:0]};
    endtask

    // Advance the model across a rising edge using the same inputs.
    task automatic model_tick();
        if (!reset_n) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (e_ld_pc == 0 && m_stall < CNT_MAX) m_stall++;
            if (v_de_br_stall && !dep_stall && !mem_stall) begin
                m_mode = 2; m_wait = 0;
            end
        end else begin
            if (v_mem_br_stall && !mem_stall) begin
                if (m_br < CNT_MAX) m_br++;
                m_mode = 1;
            end else if (!mem_stall) begin
                if (m_wait == MAXW - 1) begin
                    m_err = 1; m_mode = 1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end
        end
    endtask

    task automatic drive(input logic ic, input logic dep, input logic vde,
                         input logic vag, input logic vmem, input logic ms,
                         input logic [1:0] pm);
        icache_r = ic; dep_stall = dep; v_de_br_stall = vde; v_agex_br_stall = vag;
        v_mem_br_stall = vmem; mem_stall = ms; mem_pcmux = pm;
    endtask

    task automatic settle();
        @(negedge clk);
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 2'd2);
        model_reset();
        #3;
        model_comb();
        checks++;
        if (obs_vec !== exp_vec) $display("FAIL reset_outputs got=%h want=%h", obs_vec, exp_vec);
        else passed++;
        checks++;
        if ({ld_agex, ld_de, ld_pc, ctrl_state} !== 5'b11000)
            $display("FAIL reset_loads got=%b want=11000", {ld_agex, ld_de, ld_pc, ctrl_state});
        else passed++;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_boot_run();
        drive(1, 0, 0, 0, 0, 0, 2'd0);
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (obs_vec !== exp_vec) $display("FAIL boot_run c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            checks++;
            if ({ctrl_state, ld_pc, de_v_in} !== ((c == 0) ? 4'b0000 : 4'b0111))
                $display("FAIL boot_run_seq c%0d got=%b", c, {ctrl_state, ld_pc, de_v_in});
            else passed++;
            tick();
        end
        checks++;
        if (stall_cnt !== 4'd0) $display("FAIL boot_stall_cnt got=%0d want=0", stall_cnt);
        else passed++;
    endtask

    task automatic test_dep_stall();
        drive(1, 1, 0, 0, 0, 0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if ({ld_pc, ld_de, ld_agex} !== 3'b001 || obs_vec !== exp_vec)
                $display("FAIL dep_stall c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 2'd0);
        settle();
        checks++;
        if (stall_cnt !== 4'd3) $display("FAIL dep_stall_cnt got=%0d want=3", stall_cnt);
        else passed++;
        tick();
    endtask

    task automatic test_branch();
        drive(1, 0, 1, 0, 0, 0, 2'd0);
        settle();
        checks++;
        if (obs_vec !== exp_vec || {ld_pc, ld_de, de_v_in} !== 3'b010)
            $display("FAIL branch_leave got=%h want=%h", obs_vec, exp_vec);
        else passed++;
        tick();
        drive(1, 0, 0, 1, 0, 0, 2'd0);
        settle();
        checks++;
        if (ctrl_state !== 2'd2 || de_v_in !== 1'b0 || obs_vec !== exp_vec)
            $display("FAIL branch_pend got=%h want=%h", obs_vec, exp_vec);
        else passed++;
        tick();
        drive(1, 0, 0, 0, 0, 0, 2'd0);
        settle();
        tick();
        drive(1, 0, 0, 0, 1, 0, 2'd1);
        settle();
        checks++;
        if ({ld_pc, pcmux_sel} !== 3'b101 || obs_vec !== exp_vec)
            $display("FAIL branch_resolve got=%h want=%h", obs_vec, exp_vec);
        else passed++;
        tick();
        drive(1, 0, 0, 0, 0, 0, 2'd0);
        settle();
        checks++;
        if (br_cnt !== 4'd1 || ctrl_state !== 2'd1)
            $display("FAIL branch_count got=%0d/%0d want=1/1", br_cnt, ctrl_state);
        else passed++;
        tick();
    endtask

    task automatic test_mem_stall_branch();
        drive(1, 0, 1, 0, 0, 0, 2'd0);
        settle(); tick();
        for (int c = 0; c < 20; c++) begin
            drive(1, 0, 0, 0, c[0], 1, 2'd2);
            settle();
            checks++;
            if ({ld_agex, ld_de, ld_pc} !== 3'b000 || obs_vec !== exp_vec)
                $display("FAIL memstall_hold c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            tick();
        end
        drive(1, 0, 0, 0, 1, 0, 2'd2);
        settle();
        checks++;
        if ({ld_pc, pcmux_sel, br_timeout_err} !== 4'b1100 || obs_vec !== exp_vec)
            $display("FAIL memstall_resolve got=%h want=%h", obs_vec, exp_vec);
        else passed++;
        tick();
    endtask

    task automatic test_timeout();
        drive(1, 0, 1, 0, 0, 0, 2'd0);
        settle(); tick();
        drive(1, 0, 0, 0, 0, 0, 2'd0);
        for (int c = 0; c < MAXW; c++) begin
            settle();
            checks++;
            if (ctrl_state !== 2'd2 || br_timeout_err !== 1'b0 || obs_vec !== exp_vec)
                $display("FAIL timeout_wait c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (br_timeout_err !== 1'b1 || (c == 0 && ctrl_state !== 2'd1) || obs_vec !== exp_vec)
                $display("FAIL timeout_sticky c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 1, 0, 0, 0, 2'd0);
        settle(); tick();
        drive(1, 0, 0, 0, 1, 0, 2'd1);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        model_comb();
        checks++;
        if ({ctrl_state, stall_cnt, br_cnt, br_timeout_err, ld_pc} !== '0 || obs_vec !== exp_vec)
            $display("FAIL async_reset got=%h want=%h", obs_vec, exp_vec);
        else passed++;
        #1;
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 2'd0);
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (ctrl_state !== c[1:0] || obs_vec !== exp_vec)
                $display("FAIL async_release c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            tick();
        end
    endtask

    task automatic test_saturation();
        drive(0, 1, 0, 0, 0, 0, 2'd0);
        for (int c = 0; c < 20; c++) begin
            settle(); tick();
        end
        settle();
        checks++;
        if (stall_cnt !== 4'd15 || obs_vec !== exp_vec)
            $display("FAIL stall_saturate got=%0d want=15", stall_cnt);
        else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)));
            settle();
            checks++;
            if (obs_vec !== exp_vec) $display("FAIL random c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot_run();
        test_dep_stall();
        test_branch();
        test_mem_stall_branch();
        test_timeout();
        test_async_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
